// File: rtl/dino_pkg.sv
// Shared game constants and state encoding for the dino runner.
// Used by the obstacle scheduler and the player logic.
package dino_pkg;

    localparam int DINO_COORD_W  = 12;
    localparam int DINO_SCREEN_W = 640;
    localparam int DINO_GROUND_Y = 400;

    localparam logic [15:0] DINO_LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } game_state_e;

endpackage

// File: rtl/dino_lfsr.sv
// 16-bit Galois LFSR, right-shifting, with seed and enable.
// Only the low OUT_W bits are exposed to keep consumers narrow.
module dino_lfsr
    import dino_pkg::*;
#(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          OUT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    output logic [OUT_W-1:0] o_bits
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Shift right and fold the tap mask in when a one falls out.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]};
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ DINO_LFSR_MASK;
        end
    end

    // State register; reset restores the seed.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lfsr_q <= SEED;
        end else if (i_en) begin
            lfsr_q <= lfsr_d;
        end
    end

    assign o_bits = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/obstacle_scheduler.sv
// Cactus obstacle pool (three slots) plus the RUN/HALT game FSM.
// Scrolls, frees and spawns obstacles once per frame tick.
module obstacle_scheduler
    import dino_pkg::*;
#(
    parameter int          SCREEN_W          = DINO_SCREEN_W,
    parameter int          GROUND_Y          = DINO_GROUND_Y,
    parameter int          CACTUS_W          = 16,
    parameter int          CACTUS_H          = 32,
    parameter int          SPEED_INIT        = 2,
    parameter int          SPEED_MAX         = 8,
    parameter int          SPEED_STEP_FRAMES = 600,
    parameter int          GAP_MIN           = 40,
    parameter logic [5:0]  GAP_MASK          = 6'h3F,
    parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ani_stb,
    input  logic        i_animate,
    input  logic        i_start,
    input  logic        i_collide,
    output logic [35:0] o_x1,
    output logic [35:0] o_x2,
    output logic [35:0] o_y1,
    output logic [35:0] o_y2,
    output logic [2:0]  o_active,
    output logic [1:0]  o_state,
    output logic [3:0]  o_speed,
    output logic [15:0] o_score
);

    localparam int CW    = DINO_COORD_W;
    localparam int NSLOT = 3;
    localparam int FW    = $clog2(SPEED_STEP_FRAMES);

    localparam logic [CW-1:0] SPAWN_X2 = CW'(SCREEN_W + CACTUS_W);
    localparam logic [CW-1:0] CAC_W    = CW'(CACTUS_W);
    localparam logic [CW-1:0] Y_TOP    = CW'(GROUND_Y - CACTUS_H);
    localparam logic [CW-1:0] Y_BOT    = CW'(GROUND_Y);
    localparam logic [3:0]    SPD_INIT = 4'(SPEED_INIT);
    localparam logic [3:0]    SPD_MAX  = 4'(SPEED_MAX);
    localparam logic [FW-1:0] STEP_END = FW'(SPEED_STEP_FRAMES - 1);
    localparam logic [7:0]    GAP_INIT = 8'(GAP_MIN);

    game_state_e state_q, state_d;
    logic        tick;
    logic        restart;
    logic        run_tick;

    logic [NSLOT-1:0]         act_q, act_d, act_mv;
    logic [NSLOT-1:0][CW-1:0] x2_q, x2_d, x2_mv;
    logic [NSLOT-1:0][CW-1:0] x1_q, x1_n;
    logic [NSLOT-1:0][CW-1:0] y1_q, y1_n;
    logic [NSLOT-1:0][CW-1:0] y2_q, y2_n;

    logic [3:0]    speed_q, speed_d;
    logic [15:0]   score_q, score_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [7:0]    gap_q, gap_d;

    logic [NSLOT-1:0] free_slots;
    logic [NSLOT-1:0] spawn_oh;
    logic             do_spawn;
    logic [5:0]       rnd;

    assign tick = i_animate & i_ani_stb;

    dino_lfsr #(
        .SEED  (LFSR_SEED),
        .OUT_W (6)
    ) u_lfsr (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (1'b1),
        .o_bits (rnd)
    );

    // Game FSM next state; collision beats a coincident tick.
    always_comb begin
        state_d  = state_q;
        restart  = 1'b0;
        run_tick = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_RUN;
                    restart = 1'b1;
                end
            end
            ST_RUN: begin
                if (i_collide) begin
                    state_d = ST_HALT;
                end else begin
                    run_tick = tick;
                end
            end
            ST_HALT: begin
                if (i_start) begin
                    state_d = ST_RUN;
                    restart = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Per-slot scroll; a slot that would reach x<=0 is freed instead.
    for (genvar k = 0; k < NSLOT; k++) begin : g_slot
        logic at_edge;
        assign at_edge   = x2_q[k] <= {{(CW-4){1'b0}}, speed_q};
        assign act_mv[k] = act_q[k] & ~at_edge;
        assign x2_mv[k]  = act_mv[k] ? x2_q[k] - {{(CW-4){1'b0}}, speed_q}
                                     : '0;
        assign x1_n[k]   = (act_d[k] && (x2_d[k] > CAC_W))
                           ? x2_d[k] - CAC_W : '0;
        assign y1_n[k]   = act_d[k] ? Y_TOP : '0;
        assign y2_n[k]   = act_d[k] ? Y_BOT : '0;
    end

    // A slot counts as free only if it was inactive at the start of
    // the tick, so a slot freed this tick is refilled on the next one.
    assign free_slots = ~act_q;
    assign spawn_oh   = free_slots & (~free_slots + 3'd1);
    assign do_spawn   = (gap_q == 8'd0) && (|free_slots);

    // Frame update: move, gap countdown, spawn, score and speed.
    always_comb begin
        act_d   = act_q;
        x2_d    = x2_q;
        speed_d = speed_q;
        score_d = score_q;
        frame_d = frame_q;
        gap_d   = gap_q;
        if (restart) begin
            act_d   = '0;
            x2_d    = '0;
            speed_d = SPD_INIT;
            score_d = '0;
            frame_d = '0;
            gap_d   = GAP_INIT;
        end else if (run_tick) begin
            act_d = act_mv;
            x2_d  = x2_mv;
            if (gap_q != 8'd0) begin
                gap_d = gap_q - 8'd1;
            end
            if (do_spawn) begin
                for (int k = 0; k < NSLOT; k++) begin
                    if (spawn_oh[k]) begin
                        act_d[k] = 1'b1;
                        x2_d[k]  = SPAWN_X2;
                    end
                end
                gap_d = GAP_INIT + {2'b00, rnd & GAP_MASK};
            end
            if (score_q != 16'hFFFF) begin
                score_d = score_q + 16'd1;
            end
            if (frame_q == STEP_END) begin
                frame_d = '0;
                if (speed_q < SPD_MAX) begin
                    speed_d = speed_q + 4'd1;
                end
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end
    end

    // Game state and registered rectangle outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            act_q   <= '0;
            x2_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            y2_q    <= '0;
            speed_q <= SPD_INIT;
            score_q <= '0;
            frame_q <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            x2_q    <= x2_d;
            x1_q    <= x1_n;
            y1_q    <= y1_n;
            y2_q    <= y2_n;
            speed_q <= speed_d;
            score_q <= score_d;
            frame_q <= frame_d;
            gap_q   <= gap_d;
        end
    end

    assign o_x1     = x1_q;
    assign o_x2     = x2_q;
    assign o_y1     = y1_q;
    assign o_y2     = y2_q;
    assign o_active = act_q;
    assign o_state  = state_q;
    assign o_speed  = speed_q;
    assign o_score  = score_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Bench for obstacle_scheduler: reference model feeding a scoreboard,
// a directed vector table and hand-written corner-case sequences.
module tb_obstacle_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        collide = 1'b0;
    logic        anim = 1'b0;
    logic        stb = 1'b0;
    logic [35:0] x1, x2, y1, y2;
    logic [2:0]  act;
    logic [1:0]  st;
    logic [3:0]  spd;
    logic [15:0] score;

    always #5 clk = ~clk;

    obstacle_scheduler dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_ani_stb (stb),
        .i_animate (anim),
        .i_start   (start),
        .i_collide (collide),
        .o_x1      (x1),
        .o_x2      (x2),
        .o_y1      (y1),
        .o_y2      (y2),
        .o_active  (act),
        .o_state   (st),
        .o_speed   (spd),
        .o_score   (score)
    );

    typedef struct packed {
        logic [1:0]  st;
        logic [2:0]  act;
        logic [35:0] x1;
        logic [35:0] x2;
        logic [35:0] y1;
        logic [35:0] y2;
        logic [3:0]  spd;
        logic [15:0] score;
    } exp_t;

    typedef struct {
        bit          r, s, c, a, b;
        logic [1:0]  st;
        logic [15:0] score;
    } vec_t;

    exp_t sbq[$];
    exp_t last;
    exp_t snap;
    vec_t vt[14];
    int   n_chk = 0;
    int   n_pass = 0;
    int   ncyc = 0;

    // Reference model of the game state.
    int        m_st;
    bit [2:0]  m_act;
    int        m_x2[3];
    int        m_spd, m_score, m_frame, m_gap;
    bit [15:0] m_lfsr;

    function automatic void m_restart();
        m_st = 1;
        m_act = 3'b000;
        for (int k = 0; k < 3; k++) m_x2[k] = 0;
        m_spd = 2;
        m_score = 0;
        m_frame = 0;
        m_gap = 40;
    endfunction

    function automatic void m_tick(bit [15:0] l);
        bit [2:0] was_free;
        bit       gap0;
        bit       done;
        was_free = ~m_act;
        gap0 = (m_gap == 0);
        done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (m_act[k]) begin
                if (m_x2[k] <= m_spd) begin
                    m_act[k] = 1'b0;
                    m_x2[k] = 0;
                end else begin
                    m_x2[k] = m_x2[k] - m_spd;
                end
            end
        end
        if (m_gap > 0) m_gap = m_gap - 1;
        if (gap0) begin
            for (int k = 0; k < 3; k++) begin
                if (!done && was_free[k]) begin
                    m_act[k] = 1'b1;
                    m_x2[k] = 656;
                    m_gap = 40 + int'(l[5:0]);
                    done = 1'b1;
                end
            end
        end
        if (m_score < 65535) m_score = m_score + 1;
        m_frame = m_frame + 1;
        if (m_frame == 600) begin
            m_frame = 0;
            if (m_spd < 8) m_spd = m_spd + 1;
        end
    endfunction

    function automatic void m_step(bit r, bit s, bit c, bit a, bit b);
        bit [15:0] l_old;
        if (r) begin
            m_st = 0;
            m_act = 3'b000;
            for (int k = 0; k < 3; k++) m_x2[k] = 0;
            m_spd = 2;
            m_score = 0;
            m_frame = 0;
            m_gap = 0;
            m_lfsr = 16'hACE1;
            return;
        end
        l_old = m_lfsr;
        m_lfsr = m_lfsr >> 1;
        if (l_old[0]) m_lfsr = m_lfsr ^ 16'hB400;
        case (m_st)
            0: if (s) m_restart();
            1: if (c) m_st = 2; else if (a && b) m_tick(l_old);
            2: if (s) m_restart();
            default: m_st = 0;
        endcase
    endfunction

    function automatic exp_t m_out();
        exp_t e;
        e = '0;
        e.st = 2'(m_st);
        e.act = m_act;
        e.spd = 4'(m_spd);
        e.score = 16'(m_score);
        for (int k = 0; k < 3; k++) begin
            if (m_act[k]) begin
                e.x2[k*12 +: 12] = 12'(m_x2[k]);
                e.x1[k*12 +: 12] = (m_x2[k] > 16) ? 12'(m_x2[k] - 16) : 12'd0;
                e.y1[k*12 +: 12] = 12'd368;
                e.y2[k*12 +: 12] = 12'd400;
            end
        end
        return e;
    endfunction

    task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, got, want);
    endtask

    task automatic bound_fail(string nm);
        n_chk++;
        $display("FAIL %s: cycle budget expired", nm);
    endtask

    // One clock: drive inputs, push model expectation, compare after edge.
    task automatic cyc(bit r, bit s, bit c, bit a, bit b);
        exp_t g;
        rst = r;
        start = s;
        collide = c;
        anim = a;
        stb = b;
        m_step(r, s, c, a, b);
        sbq.push_back(m_out());
        @(posedge clk);
        #1;
        ncyc++;
        last = sbq.pop_front();
        g.st = st;
        g.act = act;
        g.x1 = x1;
        g.x2 = x2;
        g.y1 = y1;
        g.y2 = y2;
        g.spd = spd;
        g.score = score;
        n_chk++;
        if (g === last) n_pass++;
        else $display("FAIL sb cyc %0d: got st=%0d act=%b x1=%h x2=%h y1=%h y2=%h spd=%0d sc=%0d want st=%0d act=%b x1=%h x2=%h y1=%h y2=%h spd=%0d sc=%0d",
                      ncyc, g.st, g.act, g.x1, g.x2, g.y1, g.y2, g.spd,
                      g.score, last.st, last.act, last.x1, last.x2,
                      last.y1, last.y2, last.spd, last.score);
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        int guard;

        vt[0]  = '{1, 0, 0, 0, 0, 2'd0, 16'd0};
        vt[1]  = '{0, 0, 0, 1, 1, 2'd0, 16'd0};
        vt[2]  = '{0, 1, 0, 0, 0, 2'd1, 16'd0};
        vt[3]  = '{0, 0, 0, 1, 1, 2'd1, 16'd1};
        vt[4]  = '{0, 0, 0, 1, 0, 2'd1, 16'd1};
        vt[5]  = '{0, 0, 0, 0, 1, 2'd1, 16'd1};
        vt[6]  = '{0, 1, 0, 1, 1, 2'd1, 16'd2};
        vt[7]  = '{0, 0, 1, 1, 1, 2'd2, 16'd2};
        vt[8]  = '{0, 0, 0, 1, 1, 2'd2, 16'd2};
        vt[9]  = '{0, 0, 1, 0, 0, 2'd2, 16'd2};
        vt[10] = '{0, 1, 1, 0, 0, 2'd1, 16'd0};
        vt[11] = '{0, 0, 0, 1, 1, 2'd1, 16'd1};
        vt[12] = '{0, 0, 1, 0, 0, 2'd2, 16'd1};
        vt[13] = '{1, 0, 0, 1, 1, 2'd0, 16'd0};

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_state", 64'(st), 64'd0);
        chk("rst_speed", 64'(spd), 64'd2);
        chk("rst_coords", 64'(|{x1, x2, y1, y2, act}), 64'd0);

        for (int i = 0; i < 14; i++) begin
            cyc(vt[i].r, vt[i].s, vt[i].c, vt[i].a, vt[i].b);
            chk($sformatf("vec%0d_state", i), 64'(st), 64'(vt[i].st));
            chk($sformatf("vec%0d_score", i), 64'(score), 64'(vt[i].score));
        end

        // First spawn after the initial 40-frame gap.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(40);
        chk("no_spawn_yet", 64'(act), 64'd0);
        ticks(1);
        chk("spawn_act", 64'(act), 64'b001);
        chk("spawn_x2", 64'(x2[11:0]), 64'd656);
        chk("spawn_x1", 64'(x1[11:0]), 64'd640);
        chk("spawn_y1", 64'(y1[11:0]), 64'd368);
        chk("spawn_y2", 64'(y2[11:0]), 64'd400);
        ticks(1);
        chk("move_x2", 64'(x2[11:0]), 64'd654);

        // Pool full with gap expired: spawn must wait.
        guard = 0;
        while (!(m_act == 3'b111 && m_gap == 0) && guard < 1000) begin
            ticks(1);
            guard++;
        end
        if (guard >= 1000) bound_fail("full_wait");
        ticks(1);
        chk("full_no_spawn", 64'(act), 64'b111);

        // Slot 0 reaches the left edge, frees, then is refilled.
        guard = 0;
        while (m_x2[0] != 2 && guard < 1000) begin
            ticks(1);
            guard++;
        end
        if (guard >= 1000) bound_fail("edge_wait");
        chk("edge_x2", 64'(x2[11:0]), 64'd2);
        ticks(1);
        chk("freed_act", 64'(act), 64'b110);
        chk("freed_fields",
            64'({x1[11:0], x2[11:0], y1[11:0], y2[11:0]}), 64'd0);
        ticks(1);
        chk("refill_act", 64'(act), 64'b111);
        chk("refill_x2", 64'(x2[11:0]), 64'd656);

        // Speed ramp and saturation.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(599);
        chk("spd_599", 64'(spd), 64'd2);
        ticks(1);
        chk("spd_600", 64'(spd), 64'd3);
        ticks(2999);
        chk("spd_3599", 64'(spd), 64'd7);
        ticks(1);
        chk("spd_3600", 64'(spd), 64'd8);
        ticks(600);
        chk("spd_sat", 64'(spd), 64'd8);

        // Collision coincident with a tick freezes everything.
        snap = last;
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("halt_state", 64'(st), 64'd2);
        chk("halt_x2", x2[35:0], snap.x2);
        chk("halt_act", 64'(act), 64'(snap.act));
        chk("halt_score", 64'(score), 64'(snap.score));
        ticks(3);
        chk("halt_hold", x2[35:0], snap.x2);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("restart_state", 64'(st), 64'd1);
        chk("restart_act", 64'(act), 64'd0);
        chk("restart_score", 64'(score), 64'd0);
        chk("restart_speed", 64'(spd), 64'd2);

        // Reset mid-run with two live obstacles.
        guard = 0;
        while ($countones(m_act) < 2 && guard < 1000) begin
            ticks(1);
            guard++;
        end
        if (guard >= 1000) bound_fail("two_wait");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("mrst_state", 64'(st), 64'd0);
        chk("mrst_act", 64'(act), 64'd0);
        chk("mrst_coords", 64'(|{x1, x2, y1, y2}), 64'd0);
        chk("mrst_speed", 64'(spd), 64'd2);
        chk("mrst_score", 64'(score), 64'd0);

        // Post-reset run exercises the reseeded LFSR via spawn gaps.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(250);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
